// File: rtl/dest_arbiter_if.sv
// Bundle between the per-destination filter/source queues and the output scheduler.
// The arbiter uses the slave view; whatever feeds the requests and sinks the stream uses the master view.
interface dest_arbiter_if #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int WIDTH_SEL  = $clog2(PORT_NUB);
  localparam int WIDTH_PORT = 2*WIDTH_SEL + DATA_WIDTH;

  logic [PORT_NUB*WIDTH_PORT-1:0] port_in;
  logic [PORT_NUB-1:0]            port_vaild;
  logic [PORT_NUB-1:0]            grant;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH_SEL-1:0]           out_rx;
  logic [WIDTH_SEL-1:0]           out_tx;
  logic [DATA_WIDTH-1:0]          out_data;

  modport master (
    output port_in, port_vaild, out_ready,
    input  grant, out_valid, out_rx, out_tx, out_data
  );

  modport slave (
    input  port_in, port_vaild, out_ready,
    output grant, out_valid, out_rx, out_tx, out_data
  );
endinterface

// File: rtl/dest_arbiter.sv
// Per-destination output scheduler: rotating-priority grant with bounded bursts,
// feeding a single registered valid/ready beat toward one destination port.
module dest_arbiter #(
  parameter int PORT_NUB   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dest_arbiter_if.slave bus,
  output logic          busy
);
  localparam int WIDTH_SEL  = $clog2(PORT_NUB);
  localparam int WIDTH_PORT = 2*WIDTH_SEL + DATA_WIDTH;
  localparam int WIDTH_CNT  = $clog2(MAX_BURST + 1);
  localparam int WIDTH_IDX  = WIDTH_SEL + 1;

  localparam logic [WIDTH_SEL-1:0] LAST_PORT = WIDTH_SEL'(PORT_NUB - 1);
  localparam logic [WIDTH_CNT-1:0] CNT_MAX   = WIDTH_CNT'(MAX_BURST);
  localparam logic [WIDTH_IDX-1:0] PORT_NUM  = WIDTH_IDX'(PORT_NUB);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                  r_state;
  logic [WIDTH_SEL-1:0]    r_ptr;
  logic [WIDTH_SEL-1:0]    r_owner;
  logic [WIDTH_CNT-1:0]    r_cnt;
  logic                    r_out_valid;
  logic [WIDTH_SEL-1:0]    r_out_rx;
  logic [WIDTH_SEL-1:0]    r_out_tx;
  logic [DATA_WIDTH-1:0]   r_out_data;

  state_t                  w_state_nxt;
  logic [WIDTH_SEL-1:0]    w_ptr_nxt;
  logic [WIDTH_SEL-1:0]    w_owner_nxt;
  logic [WIDTH_CNT-1:0]    w_cnt_nxt;
  logic                    w_adv;
  logic                    w_load;
  logic [WIDTH_SEL-1:0]    w_sel;
  logic [PORT_NUB-1:0]     w_grant;
  logic [WIDTH_PORT-1:0]   w_slice;
  logic [WIDTH_SEL-1:0]    w_owner_inc;
  logic [WIDTH_SEL-1:0]    w_arb_start;
  logic                    w_arb_found;
  logic [WIDTH_SEL-1:0]    w_arb_win;
  logic [WIDTH_IDX-1:0]    w_idx;

  // Modulo increment that also wraps correctly for non-power-of-2 port counts.
  function automatic logic [WIDTH_SEL-1:0] inc_wrap(input logic [WIDTH_SEL-1:0] v);
    return (v == LAST_PORT) ? '0 : v + WIDTH_SEL'(1);
  endfunction

  assign w_adv       = !r_out_valid || bus.out_ready;
  assign w_owner_inc = inc_wrap(r_owner);
  // A finishing burst re-arbitrates from owner+1 in the same cycle, so there is no bubble.
  assign w_arb_start = (r_state == S_BURST) ? w_owner_inc : r_ptr;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_arb_found = 1'b0;
    w_arb_win   = '0;
    w_idx       = '0;
    for (int k = 0; k < PORT_NUB; k++) begin
      w_idx = {1'b0, w_arb_start} + WIDTH_IDX'(k);
      if (w_idx >= PORT_NUM) w_idx = w_idx - PORT_NUM;
      if (!w_arb_found && bus.port_vaild[w_idx[WIDTH_SEL-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_win   = w_idx[WIDTH_SEL-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_sel       = r_owner;
    if (rst_n && w_adv) begin
      if (r_state == S_BURST && bus.port_vaild[r_owner] && r_cnt < CNT_MAX) begin
        w_load    = 1'b1;
        w_cnt_nxt = r_cnt + WIDTH_CNT'(1);
      end else begin
        if (r_state == S_BURST) w_ptr_nxt = w_owner_inc;
        if (w_arb_found) begin
          w_load      = 1'b1;
          w_sel       = w_arb_win;
          w_owner_nxt = w_arb_win;
          w_cnt_nxt   = WIDTH_CNT'(1);
          if (MAX_BURST > 1) begin
            w_state_nxt = S_BURST;
          end else begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = inc_wrap(w_arb_win);
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_load) w_grant[w_sel] = 1'b1;
  end

  assign w_slice = bus.port_in[w_sel*WIDTH_PORT +: WIDTH_PORT];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_rx    <= '0;
      r_out_tx    <= '0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_adv) begin
        r_out_valid <= w_load;
        if (w_load) begin
          r_out_rx   <= w_slice[WIDTH_PORT-1 -: WIDTH_SEL];
          r_out_tx   <= w_slice[DATA_WIDTH +: WIDTH_SEL];
          r_out_data <= w_slice[DATA_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.grant     = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_rx    = r_out_rx;
  assign bus.out_tx    = r_out_tx;
  assign bus.out_data  = r_out_data;
  assign busy          = (r_state == S_BURST);
endmodule
